// File: rtl/addac_acc.sv
// Two WIDTH-bit accumulators with load/add/sub and a multi-cycle shift-add
// multiply-accumulate. Results can wrap or saturate, and each accumulator has a sticky flag.
module addac_acc #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sel,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] saida1,
  output logic [WIDTH-1:0] saida2,
  output logic             ovf1,
  output logic             ovf2,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   acc_reg [2];
  logic [1:0]         ovf_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               mac_sel_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] product_reg;
  logic [CW-1:0]      count_reg;

  logic [WIDTH-1:0]   acc_sel;
  logic [WIDTH-1:0]   acc_mac;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic               borrow;
  logic [2*WIDTH:0]   total;
  logic               total_ovf;

  always_comb begin
    acc_sel   = acc_reg[sel];
    acc_mac   = acc_reg[mac_sel_reg];
    sum       = {1'b0, acc_sel} + {1'b0, c};
    diff      = acc_sel - d;
    borrow    = d > acc_sel;
    total     = {{(WIDTH+1){1'b0}}, acc_mac} + {1'b0, product_reg};
    // Any set bit above the accumulator width means the MAC result does not fit
    total_ovf = |total[2*WIDTH:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      acc_reg[0]  <= '0;
      acc_reg[1]  <= '0;
      ovf_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      mac_sel_reg <= 1'b0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      product_reg <= '0;
      count_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            case (op)
              2'b00: begin
                acc_reg[sel] <= c;
                ovf_reg[sel] <= 1'b0;
                done_reg     <= 1'b1;
              end
              2'b01: begin
                done_reg <= 1'b1;
                if (sum[WIDTH]) begin
                  ovf_reg[sel] <= 1'b1;
                  acc_reg[sel] <= SAT ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                end else begin
                  acc_reg[sel] <= sum[WIDTH-1:0];
                end
              end
              2'b10: begin
                done_reg <= 1'b1;
                if (borrow) begin
                  ovf_reg[sel] <= 1'b1;
                  acc_reg[sel] <= SAT ? {WIDTH{1'b0}} : diff;
                end else begin
                  acc_reg[sel] <= diff;
                end
              end
              default: begin
                mac_sel_reg <= sel;
                mcand_reg   <= {{WIDTH{1'b0}}, c};
                mplier_reg  <= d;
                product_reg <= '0;
                count_reg   <= '0;
                busy_reg    <= 1'b1;
                state_reg   <= MAC;
              end
            endcase
          end
        end
        MAC: begin
          // Multiplicand is pre-shifted so each step adds (c << count) when the bit is set
          if (mplier_reg[0]) begin
            product_reg <= product_reg + mcand_reg;
          end
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + CW'(1);
          if (count_reg == CW'(WIDTH-1)) begin
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          if (total_ovf) begin
            ovf_reg[mac_sel_reg] <= 1'b1;
            acc_reg[mac_sel_reg] <= SAT ? {WIDTH{1'b1}} : total[WIDTH-1:0];
          end else begin
            acc_reg[mac_sel_reg] <= total[WIDTH-1:0];
          end
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign saida1 = acc_reg[0];
  assign saida2 = acc_reg[1];
  assign ovf1   = ovf_reg[0];
  assign ovf2   = ovf_reg[1];
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: doc/addac_acc.md
# addac_acc

Parametrised sequential successor to the 4-bit combinational add/accumulate unit. Two WIDTH-bit unsigned accumulators (saida1, saida2) are loaded, added to, subtracted from, or updated by a multi-cycle shift-add multiply-accumulate under a start/busy/done handshake. Optional saturation replaces wrap-around, and sticky overflow flags are added. It sits in the same datapath slot as the 4-bit unit and is checked by a clocked vector testbench.

## Interface
- WIDTH, 8, data/accumulator width in bits (≥2)
- SAT, 0, 0 = wrap-around arithmetic, 1 = saturate (clamp to 2^WIDTH−1 on overflow, 0 on underflow)

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- start  in  1  request; sampled only when busy=0
- op  in  2  00 load, 01 add, 10 subtract, 11 multiply-accumulate
- sel  in  1  target accumulator: 0 → saida1, 1 → saida2
- c  in  WIDTH  operand (load value / addend / multiplicand)
- d  in  WIDTH  operand (subtrahend / multiplier)
- saida1  out  WIDTH  accumulator 0
- saida2  out  WIDTH  accumulator 1
- ovf1  out  1  sticky overflow/underflow flag for saida1
- ovf2  out  1  sticky overflow/underflow flag for saida2
- busy  out  1  high while a multiply-accumulate is in progress
- done  out  1  one-cycle pulse: operation result is visible on saida1/saida2

## Operation
- Reset: saida1=saida2=0, ovf1=ovf2=0, busy=0, done=0, FSM → IDLE, internal product/count cleared. Reset wins over everything, including mid-MAC; the aborted MAC writes nothing.
- FSM states: IDLE, MAC, WRITE.
- IDLE, start=1, op≠11: single-cycle op on acc[sel] at that edge. done=1 next cycle. FSM stays IDLE.
  - 00: acc ← c; clears ovf[sel].
  - 01: sum = acc + c (WIDTH+1 bits). If the carry is set, ovf[sel] ← 1 and acc ← SAT ? all-ones : sum[WIDTH−1:0].
  - 10: if d > acc, ovf[sel] ← 1 and acc ← SAT ? 0 : (acc − d) mod 2^WIDTH; otherwise acc ← acc − d.
- IDLE, start=1, op=11: latch c, d and sel; clear the 2·WIDTH product and the bit counter. FSM → MAC, busy=1.
- MAC: each cycle examines one multiplier bit, LSB first. If the bit is set, product += multiplicand << count. count++. After WIDTH cycles → WRITE.
- WRITE: total = acc + product (2·WIDTH+1 bits). If total > 2^WIDTH−1, ovf ← 1 and acc ← SAT ? all-ones : total[WIDTH−1:0]; otherwise acc ← total. Then done=1, busy=0, FSM → IDLE.
- Operands c, d, sel and op are ignored while busy=1. start while busy=1 is dropped, not queued.
- The unselected accumulator and its flag never change during an operation.
- ovf flags clear only on reset or on a load (op 00) to the same accumulator.

## Timing
- Accepting edge E0 is the rising edge with reset=0, start=1, busy=0.
- Ops 00/01/10: the accumulator updates at E0. done=1 during the cycle after E0, low after E1 unless a new op is accepted at E1.
- Op 11:
  - busy=1 from after E0 until after E(WIDTH+1).
  - The accumulator and done update at E(WIDTH+1), so latency is WIDTH+1 cycles.
  - Throughput is one MAC per WIDTH+1 cycles.
- Back-to-back: start may be held high. A new op is accepted in the same cycle done=1 is shown, since busy=0 then.
- Simultaneous reset and start: reset wins, the op is not accepted, and done stays 0.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset/load, WIDTH=8: assert reset for 2 cycles → all outputs 0. Load sel=0 c=0x5A, then sel=1 c=0x33 → saida1=0x5A, saida2=0x33. One done pulse per op.
- Add/sub wrap, SAT=0: saida1=0xF0, add c=0x20 → saida1=0x10, ovf1=1. Then sub d=0x30 → saida1=0xE0, ovf1 stays 1. Load c=0 → ovf1=0.
- Saturation, SAT=1: saida2=0xF0, add c=0x20 → saida2=0xFF, ovf2=1. Load c=0x05, then sub d=0x09 → saida2=0x00, ovf2=1. saida1 unchanged throughout.
- MAC latency: saida1=0x10, op=11 c=0x07 d=0x09 → busy high for exactly 9 cycles, done at E9, saida1=0x4F, ovf1=0. Input changes during busy have no effect.
- MAC overflow/back-to-back: start held high with op=11, c=0x10, d=0x20, saida2=0 → the first result gives ovf2=1 (0x200 > 0xFF), saida2=0x00 (SAT=0) or 0xFF (SAT=1). The second MAC is accepted on the done cycle.
- Reset mid-MAC: assert reset at cycle 4 of a MAC → next cycle busy=0, done=0, saida1=saida2=0, no late write. A fresh load after reset behaves normally.
